// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: edge-detected byte capture, {error,data} storage,
// registered single-cycle read strobe, occupancy count and sticky overflow flag.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              rx_error,
  input  logic              rd_en,
  input  logic              clear_overflow,
  output logic [7:0]        rd_data,
  output logic              rd_error,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [8:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rx_ready_q;
  logic              wr_ev;
  logic              rd_acc;
  logic              wr_ok;
  logic              ovf_ev;

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign wr_ev  = rx_ready & ~rx_ready_q;
  assign rd_acc = rd_en & ~empty;
  // A full FIFO still accepts a byte when a read frees a slot in the same cycle.
  assign wr_ok  = wr_ev & (~full | rd_acc);
  assign ovf_ev = wr_ev & full & ~rd_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= 8'h00;
      rd_error   <= 1'b0;
      rx_ready_q <= 1'b1;
    end else begin
      rx_ready_q <= rx_ready;
      rd_valid   <= rd_acc;
      if (rd_acc) begin
        {rd_error, rd_data} <= mem[rd_ptr];
        rd_ptr              <= rd_ptr + 1'b1;
      end
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({wr_ok, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_ev) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr] <= {rx_error, rx_data};
    end
  end

endmodule
